code_loader: RTL and testbench

Byte-stream program loader that fills the processor's code memory and holds the core in reset until a complete, checksum-verified image has been written. It is the writer side of the code memory the processor fetches from through `code_addr`/`code_word`. It sits between a byte source (UART receiver or debug bridge) and the write port of the code RAM. Its `cpu_reset` output drives the processor's `reset`.

---
 rtl/code_loader_if.sv | 24 ++
 rtl/code_loader.sv | 125 ++++++++++++
 tb/tb_code_loader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/code_loader_if.sv
// Byte-stream input and code-RAM write port of the program loader.
interface code_loader_if #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 code_write_enable;
  logic [ADDR_SIZE-1:0] code_write_addr;
  logic [WORD_SIZE-1:0] code_write_data;

  // byte source / code RAM side
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, code_write_enable, code_write_addr, code_write_data
  );

  // loader side
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, code_write_enable, code_write_addr, code_write_data
  );
endinterface

// File: rtl/code_loader.sv
// Program loader: parses A5 / len16 / 3-byte words / xor-checksum frames,
// writes each word into code RAM and holds the core in reset until a
// frame with a matching checksum has been fully written.
module code_loader #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
) (
  input  logic          clock,
  input  logic          reset,
  code_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          load_done,
  output logic          load_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2,
    S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [7:0] HEADER = 8'hA5;

  state_t               state, state_nx;
  logic                 accept;
  logic [7:0]           len_hi;
  logic [15:0]          remaining;
  logic [ADDR_SIZE-1:0] addr_cnt;
  logic [7:0]           acc;
  logic [1:0]           b0;
  logic [7:0]           b1;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [WORD_SIZE-1:0] wr_data;

  assign accept                = bus.rx_valid && bus.rx_ready;
  // WRITE is the only cycle with no byte slot; all status flags decode state.
  assign bus.rx_ready          = (state != S_WRITE);
  assign bus.code_write_enable = (state == S_WRITE);
  assign bus.code_write_addr   = wr_addr;
  assign bus.code_write_data   = wr_data;
  assign cpu_reset             = (state != S_DONE);
  assign load_done             = (state == S_DONE);
  assign load_error            = (state == S_ERROR);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state: frame parser; only advances on accepted bytes except WRITE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (accept && bus.rx_data == HEADER) state_nx = S_LEN_HI;
      S_LEN_HI: if (accept) state_nx = S_LEN_LO;
      S_LEN_LO:
        if (accept) state_nx = ({len_hi, bus.rx_data} == 16'd0) ? S_CHECK : S_B0;
      S_B0:     if (accept) state_nx = S_B1;
      S_B1:     if (accept) state_nx = S_B2;
      S_B2:     if (accept) state_nx = S_WRITE;
      // remaining still holds the pre-decrement count here
      S_WRITE:  state_nx = (remaining == 16'd1) ? S_CHECK : S_B0;
      S_CHECK:
        if (accept) state_nx = (bus.rx_data == acc) ? S_DONE : S_ERROR;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Datapath: length, checksum accumulator, word assembly, address counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_hi    <= '0;
      remaining <= '0;
      addr_cnt  <= '0;
      acc       <= '0;
      b0        <= '0;
      b1        <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR:
          if (accept && bus.rx_data == HEADER) begin
            acc      <= '0;
            addr_cnt <= '0;
          end
        S_LEN_HI:
          if (accept) begin
            len_hi <= bus.rx_data;
            acc    <= acc ^ bus.rx_data;
          end
        S_LEN_LO:
          if (accept) begin
            remaining <= {len_hi, bus.rx_data};
            acc       <= acc ^ bus.rx_data;
          end
        S_B0:
          if (accept) begin
            b0  <= bus.rx_data[1:0];
            acc <= acc ^ bus.rx_data;
          end
        S_B1:
          if (accept) begin
            b1  <= bus.rx_data;
            acc <= acc ^ bus.rx_data;
          end
        // address/data are registered on the b2 edge so they are stable
        // for the whole WRITE strobe cycle
        S_B2:
          if (accept) begin
            acc     <= acc ^ bus.rx_data;
            wr_addr <= addr_cnt;
            wr_data <= WORD_SIZE'({b0, b1, bus.rx_data});
          end
        S_WRITE: begin
          addr_cnt  <= addr_cnt + 1'b1;
          remaining <= remaining - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_code_loader.sv
module tb_code_loader;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0]  b0, b1, b2;
    bit          bad;
    logic [17:0] data;
    bit          done;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  logic cpu_reset, load_done, load_error;
  int   total = 0, bad = 0, cyc = 0;

  code_loader_if #(.ADDR_SIZE(18), .WORD_SIZE(18)) bus ();

  code_loader #(.ADDR_SIZE(18), .WORD_SIZE(18)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [17:0] wa_q[$], wd_q[$], exp_a[$], exp_d[$];
  int          wc_q[$];
  bit          exp_done, exp_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (bus.code_write_enable === 1'b1) begin
      wa_q.push_back(bus.code_write_addr);
      wd_q.push_back(bus.code_write_data);
      wc_q.push_back(cyc);
      chk("ready_low_in_write", 32'(bus.rx_ready), 32'd0);
    end
  end

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
  endtask

  task automatic idle(input int k);
    bus.rx_valid = 1'b0;
    repeat (k) @(posedge clock);
    #1;
  endtask

  // Offer one byte, hold it until accepted (bounded), return at posedge+1.
  task automatic send(input logic [7:0] b);
    int n;
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge clock);
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL send_timeout: rx_ready stuck low for byte %0h", b);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send_q(input bq_t q, input int maxgap);
    foreach (q[i]) begin
      if (maxgap > 0) begin
        int g = int'($urandom_range(maxgap, 0));
        if (g > 0) idle(g);
      end
      send(q[i]);
    end
  endtask

  function automatic bq_t mk_frame(input bq_t pl, input bit corrupt);
    bq_t q;
    logic [7:0] x;
    logic [15:0] n = 16'(pl.size() / 3);
    q.push_back(8'hA5); q.push_back(n[15:8]); q.push_back(n[7:0]);
    x = n[15:8] ^ n[7:0];
    foreach (pl[i]) begin q.push_back(pl[i]); x ^= pl[i]; end
    q.push_back(x ^ {7'd0, corrupt});
    return q;
  endfunction

  // Reference: scan the byte stream for frames and list the expected writes
  // and final status.
  function automatic void model(input bq_t q);
    int i = 0;
    exp_a.delete(); exp_d.delete();
    exp_done = 0; exp_err = 0;
    while (i < q.size()) begin
      if (q[i] != 8'hA5) begin i++; continue; end
      begin
        int n = int'({q[i+1], q[i+2]});
        logic [7:0] x = q[i+1] ^ q[i+2];
        for (int w = 0; w < n; w++) begin
          int p = i + 3 + 3*w;
          exp_a.push_back(18'(w));
          exp_d.push_back({q[p][1:0], q[p+1], q[p+2]});
          x ^= q[p] ^ q[p+1] ^ q[p+2];
        end
        exp_done = (q[i+3+3*n] == x);
        exp_err  = !exp_done;
        i += 4 + 3*n;
      end
    end
  endfunction

  task automatic compare_model(input string tag);
    chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(exp_a.size()));
    foreach (exp_a[i]) begin
      if (i < wa_q.size()) begin
        chk({tag, "_addr"}, 32'(wa_q[i]), 32'(exp_a[i]));
        chk({tag, "_data"}, 32'(wd_q[i]), 32'(exp_d[i]));
      end
    end
    chk({tag, "_done"},  32'(load_done),  32'(exp_done));
    chk({tag, "_error"}, 32'(load_error), 32'(exp_err));
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"},  32'(bus.rx_ready), 32'd1);
    chk({tag, "_we"},        32'(bus.code_write_enable), 32'd0);
    chk({tag, "_waddr"},     32'(bus.code_write_addr), 32'd0);
    chk({tag, "_wdata"},     32'(bus.code_write_data), 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_done"},      32'(load_done), 32'd0);
    chk({tag, "_error"},     32'(load_error), 32'd0);
  endtask

  vec_t vt[5];
  bq_t  f3, q;

  initial begin
    vt[0] = '{8'h03, 8'h12, 8'h34, 1'b0, 18'h31234, 1'b1};
    vt[1] = '{8'h03, 8'h12, 8'h34, 1'b1, 18'h31234, 1'b0};
    vt[2] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 18'h3FFFF, 1'b1};
    vt[3] = '{8'hFC, 8'h00, 8'h01, 1'b0, 18'h00001, 1'b1};
    vt[4] = '{8'hA5, 8'hA5, 8'hA5, 1'b0, 18'h1A5A5, 1'b1};
    f3 = mk_frame('{8'h00, 8'h00, 8'h01, 8'h03, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h80}, 1'b0);

    reset = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_reset_vals("reset");

    // One-word frames from the table; status checked one edge after checksum.
    foreach (vt[i]) begin
      clear_mon();
      q = mk_frame('{vt[i].b0, vt[i].b1, vt[i].b2}, vt[i].bad);
      send_q(q, 0);
      chk("vec_done",  32'(load_done),  32'(vt[i].done));
      chk("vec_error", 32'(load_error), 32'(!vt[i].done));
      chk("vec_cpu_reset", 32'(cpu_reset), 32'(!vt[i].done));
      idle(2);
      chk("vec_nwrites", 32'(wa_q.size()), 32'd1);
      if (wa_q.size() > 0) begin
        chk("vec_addr", 32'(wa_q[0]), 32'd0);
        chk("vec_data", 32'(wd_q[0]), 32'(vt[i].data));
      end
    end

    // Garbage after DONE is ignored; A5 then restarts and reasserts cpu_reset.
    clear_mon();
    send(8'h11); send(8'h5A);
    chk("garbage_done_kept", 32'(load_done), 32'd1);
    chk("garbage_cpu_reset", 32'(cpu_reset), 32'd0);
    send(8'hA5);
    chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("restart_done_clr",  32'(load_done), 32'd0);
    q = f3; void'(q.pop_front());
    send_q(q, 0);                         // rx_valid held high throughout
    idle(2);
    chk("n3_nwrites", 32'(wa_q.size()), 32'd3);
    if (wa_q.size() == 3) begin
      chk("n3_addr0", 32'(wa_q[0]), 32'd0);
      chk("n3_addr1", 32'(wa_q[1]), 32'd1);
      chk("n3_addr2", 32'(wa_q[2]), 32'd2);
      chk("n3_data0", 32'(wd_q[0]), 32'h00001);
      chk("n3_data1", 32'(wd_q[1]), 32'h3FFFF);
      chk("n3_data2", 32'(wd_q[2]), 32'h20080);
      chk("n3_space01", 32'(wc_q[1] - wc_q[0]), 32'd4);
      chk("n3_space12", 32'(wc_q[2] - wc_q[1]), 32'd4);
    end
    chk("n3_done", 32'(load_done), 32'd1);

    // Empty frame.
    clear_mon();
    send_q('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
    idle(2);
    chk("n0_nwrites", 32'(wa_q.size()), 32'd0);
    chk("n0_done",  32'(load_done),  32'd1);
    chk("n0_error", 32'(load_error), 32'd0);

    // Reset between b1 and b2 of the second word.
    clear_mon();
    send_q('{8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 8'h03, 8'hFF}, 0);
    @(negedge clock);
    reset = 1'b1; bus.rx_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    check_reset_vals("midreset");
    idle(6);
    chk("midreset_nwrites", 32'(wa_q.size()), 32'd1);
    clear_mon();
    send_q(f3, 0);
    idle(2);
    model(f3);
    compare_model("after_reset");

    // Random frames with gaps and leading garbage against the model.
    for (int it = 0; it < 25; it++) begin
      bq_t pl, g;
      int n = (it % 8 == 0) ? 0 : int'($urandom_range(5, 1));
      for (int k = 0; k < 3*n; k++) pl.push_back(8'($urandom));
      for (int k = int'($urandom_range(2, 0)); k > 0; k--) begin
        logic [7:0] b = 8'($urandom);
        if (b == 8'hA5) b = 8'h11;
        g.push_back(b);
      end
      q = mk_frame(pl, ($urandom_range(3, 0) == 0));
      q = {g, q};
      clear_mon();
      send_q(q, 2);
      idle(3);
      model(q);
      compare_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
